// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer and its helpers.
package shift_pkg;

   localparam int unsigned SHIFT_WIDTH = 8;
   localparam int unsigned STATE_W     = 2;

   localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] S_LOAD  = 2'd1;
   localparam logic [STATE_W-1:0] S_SHIFT = 2'd2;
   localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/shift_amt_counter.sv
// Remaining-shift counter: loaded with the shift amount, decremented once per
// shift cycle, with a registered flag marking the cycle it reads 1.
module shift_amt_counter #(
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [AMT_W-1:0] amt_i,
   output logic             last_o
);

   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;

   // Next count; last flag is precomputed so it is valid in the cycle the count reads 1.
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      if (load_i) begin
         cnt_d  = amt_i;
         last_d = (amt_i == AMT_W'(1));
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d  = cnt_q - AMT_W'(1);
         last_d = (cnt_q == AMT_W'(2));
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for a load/shift-right register datapath:
// one load cycle, then exactly N shift cycles, then a held result.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = SHIFT_WIDTH,
   parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_value,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic             cmd_arith,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic [WIDTH-1:0] sh_load_val,
   output logic             sh_load_n,
   output logic             sh_shift,
   output logic             sh_asr,
   input  logic [WIDTH-1:0] sh_q
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [WIDTH-1:0]   value_q, value_d;
   logic [AMT_W-1:0]   amt_q, amt_d;
   logic               arith_q, arith_d;
   logic [AMT_W-1:0]   amt_sat;
   logic               cnt_last;

   // Amounts beyond the register width behave like a full-width shift.
   assign amt_sat = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;

   shift_amt_counter #(
      .AMT_W (AMT_W)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .load_i (state_q == S_LOAD),
      .dec_i  (state_q == S_SHIFT),
      .amt_i  (amt_q),
      .last_o (cnt_last)
   );

   // State and captured-command registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         value_q <= '0;
         amt_q   <= '0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         amt_q   <= amt_d;
         arith_q <= arith_d;
      end
   end

   // Next-state and control decode; datapath controls idle unless stated.
   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      amt_d       = amt_q;
      arith_d     = arith_q;
      cmd_ready   = 1'b0;
      res_valid   = 1'b0;
      res_data    = '0;
      busy        = 1'b1;
      sh_load_val = '0;
      sh_load_n   = 1'b1;
      sh_shift    = 1'b0;
      sh_asr      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               value_d = cmd_value;
               amt_d   = amt_sat;
               arith_d = cmd_arith;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            sh_load_n   = 1'b0;
            sh_load_val = value_q;
            state_d     = (amt_q != '0) ? S_SHIFT : S_DONE;
         end
         S_SHIFT: begin
            sh_shift = 1'b1;
            sh_asr   = arith_q;
            if (cnt_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Controls held, so the datapath output is stable to pass through.
            res_valid = 1'b1;
            res_data  = sh_q;
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer driving an 8-bit load/shift-right register.
module tb_shift_sequencer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned AMT_W = 4;

   logic             clk;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_value;
   logic [AMT_W-1:0] cmd_amt;
   logic             cmd_arith;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             busy;
   logic [WIDTH-1:0] sh_load_val;
   logic             sh_load_n;
   logic             sh_shift;
   logic             sh_asr;
   logic [WIDTH-1:0] sh_q;
   logic             reset_n;

   shift_sequencer #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_value   (cmd_value),
      .cmd_amt     (cmd_amt),
      .cmd_arith   (cmd_arith),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy),
      .sh_load_val (sh_load_val),
      .sh_load_n   (sh_load_n),
      .sh_shift    (sh_shift),
      .sh_asr      (sh_asr),
      .sh_q        (sh_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath: 8-bit register with active-low load and right shift (ASR replicates MSB).
   assign reset_n = ~reset;
   always @(posedge clk) begin
      if (!reset_n)       sh_q <= '0;
      else if (!sh_load_n) sh_q <= sh_load_val;
      else if (sh_shift)  sh_q <= sh_asr ? {sh_q[7], sh_q[7:1]} : {1'b0, sh_q[7:1]};
   end

   typedef struct {
      logic [WIDTH-1:0] data;
      int               lat;
      int               shifts;
      int               asrs;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: invariants every cycle, result checked against scoreboard on handshake.
   bit   in_op = 1'b0;
   bit   seen_valid = 1'b0;
   int   accept_cyc = 0;
   int   first_valid_cyc = 0;
   int   n_shift = 0;
   int   n_asr = 0;
   exp_t e;

   always @(negedge clk) begin
      if (reset) begin
         in_op = 1'b0;
      end else begin
         chk("load_shift_exclusive", 32'(!sh_load_n && sh_shift), 32'd0);
         chk("ready_valid_exclusive", 32'(cmd_ready && res_valid), 32'd0);
         chk("asr_outside_shift", 32'(sh_asr && !sh_shift), 32'd0);
         chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
         if (in_op) begin
            if (sh_shift) n_shift++;
            if (sh_asr) n_asr++;
            if (res_valid && !seen_valid) begin
               seen_valid = 1'b1;
               first_valid_cyc = cyc;
            end
            if (res_valid && res_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result actual=%0h required=none", res_data);
               end else begin
                  e = sb_q.pop_front();
                  chk("res_data", 32'(res_data), 32'(e.data));
                  chk("latency", 32'(first_valid_cyc - accept_cyc + 1), 32'(e.lat));
                  chk("shift_cycles", 32'(n_shift), 32'(e.shifts));
                  chk("asr_cycles", 32'(n_asr), 32'(e.asrs));
               end
               in_op = 1'b0;
               done_cnt++;
            end else if (res_valid && sb_q.size() > 0) begin
               chk("held_res_data", 32'(res_data), 32'(sb_q[0].data));
            end
         end else if (res_valid) begin
            checks++;
            errors++;
            $display("FAIL result_without_command actual=%0h required=none", res_data);
         end
         if (cmd_valid && cmd_ready) begin
            in_op      = 1'b1;
            seen_valid = 1'b0;
            n_shift    = 0;
            n_asr      = 0;
            accept_cyc = cyc + 1;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_load_n"}, 32'(sh_load_n), 32'd1);
      chk({tag, "_shift"}, 32'(sh_shift), 32'd0);
      chk({tag, "_asr"}, 32'(sh_asr), 32'd0);
      chk({tag, "_load_val"}, 32'(sh_load_val), 32'd0);
      chk({tag, "_res_data"}, 32'(res_data), 32'd0);
   endtask

   task automatic send(input logic [7:0] v, input logic [3:0] a, input logic ar,
                       input bit expect_res, input logic [7:0] ed,
                       input int lat, input int sh, input int asr);
      exp_t x;
      int   t = 0;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      if (expect_res) begin
         x.data = ed; x.lat = lat; x.shifts = sh; x.asrs = asr;
         sb_q.push_back(x);
      end
      cmd_value = v;
      cmd_amt   = a;
      cmd_arith = ar;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int t = 0;
      while (done_cnt < target && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_value = '0;
      cmd_amt   = '0;
      cmd_arith = 1'b0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("por");
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a shift drops the command.
      send(8'h3C, 4'd6, 1'b1, 1'b0, 8'h00, 0, 0, 0);
      repeat (2) begin @(posedge clk); #1; end
      chk("mid_shift_entered", 32'(sh_shift), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("post_reset_busy", 32'(busy), 32'd0);

      // Logical shift, zero shift, saturation, full-width arithmetic.
      send(8'hB4, 4'd3, 1'b0, 1'b1, 8'h16, 5, 3, 0);
      wait_done(1);
      send(8'hA5, 4'd0, 1'b0, 1'b1, 8'hA5, 2, 0, 0);
      wait_done(2);
      send(8'hFF, 4'd15, 1'b0, 1'b1, 8'h00, 10, 8, 0);
      wait_done(3);
      send(8'hFF, 4'd8, 1'b1, 1'b1, 8'hFF, 10, 8, 8);
      wait_done(4);

      // Backpressure: result held while consumer stalls, commands ignored.
      res_ready = 1'b0;
      send(8'h5A, 4'd1, 1'b0, 1'b1, 8'h2D, 3, 1, 0);
      repeat (4) begin @(posedge clk); #1; end
      chk("bp_in_done", 32'(res_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         cmd_valid = (i % 2 == 0);
         cmd_value = 8'h11;
         cmd_amt   = 4'd2;
         @(posedge clk); #1;
         chk("bp_valid_held", 32'(res_valid), 32'd1);
         chk("bp_data_held", 32'(res_data), 32'h2D);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_after_ready", 32'(busy), 32'd0);
      chk("bp_ready_after", 32'(cmd_ready), 32'd1);
      wait_done(5);

      // Arithmetic vs logical on a negative value.
      send(8'h81, 4'd2, 1'b1, 1'b1, 8'hE0, 4, 2, 2);
      wait_done(6);
      send(8'h81, 4'd2, 1'b0, 1'b1, 8'h20, 4, 2, 0);
      wait_done(7);

      repeat (3) begin @(posedge clk); #1; end
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
